// File: rtl/render_regs_if.sv
// Avalon-MM bus bundle between the host/test-driver master and render_regs.
// The master modport drives requests; the slave modport answers with
// read data and waitrequest.
interface render_regs_if;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic [31:0] slave_readdata;
    logic        slave_waitrequest;

    modport master (
        output slave_address,
        output slave_read,
        output slave_write,
        output slave_writedata,
        input  slave_readdata,
        input  slave_waitrequest
    );

    modport slave (
        input  slave_address,
        input  slave_read,
        input  slave_write,
        input  slave_writedata,
        output slave_readdata,
        output slave_waitrequest
    );
endinterface

// File: rtl/render_regs.sv
// render_regs: Avalon-MM register front-end of the renderer.
// Latches X/Y/TEXTURE, hands one draw command at a time to the drawing
// engine over cmd_valid/cmd_ready, and stalls the bus with waitrequest
// until the engine pulses draw_done.
// Optional feature: define RENDER_REGS_IRQ_EN to add the draw-complete
// interrupt (irq port, pending flop, STATUS bit1, IRQ_CLR at address 7).
module render_regs #(
    parameter int X_MAX = 319,
    parameter int Y_MAX = 239
) (
    input  logic                clk,
    input  logic                rst_n,
    render_regs_if.slave        bus,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic [8:0]          cmd_x,
    output logic [7:0]          cmd_y,
    output logic [6:0]          cmd_texture,
    input  logic                draw_done
`ifdef RENDER_REGS_IRQ_EN
    ,
    output logic                irq
`endif
);

    localparam logic [3:0] A_STATUS  = 4'd0;
    localparam logic [3:0] A_X       = 4'd1;
    localparam logic [3:0] A_Y       = 4'd2;
    localparam logic [3:0] A_TEXTURE = 4'd4;
    localparam logic [3:0] A_PLOT    = 4'd6;
`ifdef RENDER_REGS_IRQ_EN
    localparam logic [3:0] A_IRQ_CLR = 4'd7;
`endif

    localparam logic [31:0] X_MAX_W = 32'(X_MAX);
    localparam logic [31:0] Y_MAX_W = 32'(Y_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE
    } state_t;

    state_t      state;
    logic        busy;
    logic        wait_req;
    logic        wr_acc;
    logic        plot_wr;
    logic        rd_phase;
    logic [31:0] rdata_q;
    logic [31:0] rd_mux;
    logic [15:0] plot_cnt;
    logic [8:0]  x_q;
    logic [7:0]  y_q;
    logic [6:0]  tex_q;
    logic        irq_bit;

    // Saturate a full 32-bit unsigned write value to the legal x range.
    function automatic logic [8:0] clamp_x(input logic [31:0] wd);
        if (wd > X_MAX_W)
            return X_MAX_W[8:0];
        else
            return wd[8:0];
    endfunction

    // Saturate a full 32-bit unsigned write value to the legal y range.
    function automatic logic [7:0] clamp_y(input logic [31:0] wd);
        if (wd > Y_MAX_W)
            return Y_MAX_W[7:0];
        else
            return wd[7:0];
    endfunction

    // A read first spends one stalled cycle loading rdata_q; busy stalls everything.
    assign busy     = (state != ST_IDLE);
    assign wait_req = busy | (bus.slave_read & ~rd_phase);
    assign wr_acc   = bus.slave_write & ~wait_req;
    assign plot_wr  = wr_acc & (bus.slave_address == A_PLOT);

    assign bus.slave_waitrequest = wait_req;
    assign bus.slave_readdata    = rdata_q;

    // Command fields are the live registers; writes cannot reach them while busy.
    assign cmd_x       = x_q;
    assign cmd_y       = y_q;
    assign cmd_texture = tex_q;

    // Draw-command sequencer with registered cmd_valid and the plot counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cmd_valid <= 1'b0;
            plot_cnt  <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (plot_wr) begin
                        state     <= ST_ISSUE;
                        cmd_valid <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    // draw_done without the handshake belongs to nothing and is dropped
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        plot_cnt  <= plot_cnt + 16'd1;
                        state     <= draw_done ? ST_IDLE : ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (draw_done)
                        state <= ST_IDLE;
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_valid <= 1'b0;
                end
            endcase
        end
    end

    // Parameter registers: clamped coordinates and texture code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= 9'd0;
            y_q   <= 8'd0;
            tex_q <= 7'd0;
        end else if (wr_acc) begin
            case (bus.slave_address)
                A_X:       x_q   <= clamp_x(bus.slave_writedata);
                A_Y:       y_q   <= clamp_y(bus.slave_writedata);
                A_TEXTURE: tex_q <= bus.slave_writedata[6:0];
                default:   ;
            endcase
        end
    end

`ifdef RENDER_REGS_IRQ_EN
    logic irq_q;
    logic done_evt;
    logic irq_clr_wr;

    assign done_evt   = ((state == ST_ISSUE) & cmd_ready & draw_done) |
                        ((state == ST_WAIT_DONE) & draw_done);
    assign irq_clr_wr = wr_acc & (bus.slave_address == A_IRQ_CLR);

    // Interrupt pending flop: set on return to IDLE, clear wins only without a set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq_q <= 1'b0;
        else if (done_evt)
            irq_q <= 1'b1;
        else if (irq_clr_wr)
            irq_q <= 1'b0;
    end

    assign irq     = irq_q;
    assign irq_bit = irq_q;
`else
    assign irq_bit = 1'b0;
`endif

    // Read-data selection for the register map; holes read as zero.
    always_comb begin
        rd_mux = 32'd0;
        case (bus.slave_address)
            A_STATUS:  rd_mux = {plot_cnt, 14'd0, irq_bit, busy};
            A_X:       rd_mux = {23'd0, x_q};
            A_Y:       rd_mux = {24'd0, y_q};
            A_TEXTURE: rd_mux = {25'd0, tex_q};
            default:   rd_mux = 32'd0;
        endcase
    end

    // Two-cycle read: capture data while stalled, release it the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_phase <= 1'b0;
            rdata_q  <= 32'd0;
        end else if (rd_phase) begin
            rd_phase <= 1'b0;
        end else if (bus.slave_read && !busy) begin
            rdata_q  <= rd_mux;
            rd_phase <= 1'b1;
        end
    end

endmodule

// File: tb/tb_render_regs.sv
// Bench for render_regs: directed bus transactions and engine handshakes.
// Expected read data and draw commands are queued when issued and popped
// by a monitor when the DUT presents them.
module tb_render_regs;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    render_regs_if bus();

    logic       cmd_valid;
    logic       cmd_ready;
    logic [8:0] cmd_x;
    logic [7:0] cmd_y;
    logic [6:0] cmd_texture;
    logic       draw_done;
`ifdef RENDER_REGS_IRQ_EN
    logic       irq;
    localparam logic [31:0] IRQB = 32'h0000_0002;
`else
    localparam logic [31:0] IRQB = 32'h0000_0000;
`endif

    render_regs dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_texture (cmd_texture),
        .draw_done   (draw_done)
`ifdef RENDER_REGS_IRQ_EN
        ,
        .irq         (irq)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_q[$];
    string       rd_n[$];
    logic [23:0] cmd_q[$];
    bit          bg_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        bus.slave_address   = a;
        bus.slave_writedata = d;
        bus.slave_write     = 1'b1;
        #1;
        while (bus.slave_waitrequest && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("write_timeout", n, 0);
        @(posedge clk);
        #1;
        bus.slave_write = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] exp,
                            input string name, output int waits);
        int n = 0;
        rd_q.push_back(exp);
        rd_n.push_back(name);
        @(negedge clk);
        bus.slave_address = a;
        bus.slave_read    = 1'b1;
        #1;
        while (bus.slave_waitrequest && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("read_timeout", n, 0);
        waits = n;
        @(posedge clk);
        #1;
        bus.slave_read = 1'b0;
    endtask

    // Issue PLOT and complete the handshake, leaving the DUT in WAIT_DONE.
    task automatic plot_handshake(input logic [23:0] exp_cmd);
        cmd_q.push_back(exp_cmd);
        bus_write(4'd6, 32'd1);
        @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        draw_done = 1'b1;
        @(negedge clk);
        draw_done = 1'b0;
    endtask

    // Monitor: read data in the released cycle, command fields at handshake.
    always begin
        @(negedge clk);
        #2;
        if (bus.slave_read && !bus.slave_waitrequest) begin
            if (rd_q.size() == 0)
                chk("read_unexpected", 1, 0);
            else
                chk(rd_n.pop_front(), bus.slave_readdata, rd_q.pop_front());
        end
        if (cmd_valid && cmd_ready && rst_n) begin
            if (cmd_q.size() == 0)
                chk("cmd_unexpected", 1, 0);
            else
                chk("cmd_fields", {8'd0, cmd_x, cmd_y, cmd_texture}, {8'd0, cmd_q.pop_front()});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int bad;
        int n;
        bus.slave_address   = 4'd0;
        bus.slave_read      = 1'b0;
        bus.slave_write     = 1'b0;
        bus.slave_writedata = 32'd0;
        cmd_ready = 1'b0;
        draw_done = 1'b0;
        rst_n     = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_waitrequest", bus.slave_waitrequest, 0);
        chk("rst_readdata", bus.slave_readdata, 0);
        chk("rst_cmd_xyt", {cmd_x, cmd_y, cmd_texture}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        bus_read(4'd0, 32'h0, "status_after_reset", w);
        chk("read_wait_cycles", w, 1);

        // First draw with slow engine
        bus_write(4'd1, 32'd159);
        bus_write(4'd2, 32'd119);
        bus_write(4'd4, 32'h06);
        cmd_q.push_back({9'd159, 8'd119, 7'd6});
        bus_write(4'd6, 32'd0);
        @(negedge clk);
        #1;
        chk("plot_cmd_valid", cmd_valid, 1);
        chk("plot_waitrequest", bus.slave_waitrequest, 1);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (!cmd_valid || !bus.slave_waitrequest) bad++;
        end
        @(negedge clk);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        #1;
        chk("valid_drop_after_hs", cmd_valid, 0);
        repeat (9) begin
            @(negedge clk);
            #1;
            if (!bus.slave_waitrequest) bad++;
        end
        @(negedge clk);
        draw_done = 1'b1;
        #1;
        if (!bus.slave_waitrequest) bad++;
        chk("busy_stall_cycles", bad, 0);
        @(negedge clk);
        draw_done = 1'b0;
        #1;
        chk("wait_low_after_done", bus.slave_waitrequest, 0);
        bus_read(4'd0, 32'h0001_0000 | IRQB, "status_one_plot", w);

        // Clamping and unmapped addresses
        bus_write(4'd1, 32'd400);
        bus_write(4'd2, 32'd1000);
        bus_read(4'd1, 32'd319, "x_clamped", w);
        bus_read(4'd2, 32'd239, "y_clamped", w);
        bus_write(4'd3, 32'hFFFF_FFFF);
        bus_read(4'd3, 32'd0, "addr3_reads_zero", w);
        bus_read(4'd1, 32'd319, "x_after_addr3", w);
        bus_read(4'd4, 32'd6, "tex_after_addr3", w);
        bus_read(4'd6, 32'd0, "plot_reads_zero", w);
        bus_read(4'd0, 32'h0001_0000 | IRQB, "status_after_addr3", w);

        // Handshake and completion in the same cycle
        cmd_q.push_back({9'd319, 8'd239, 7'd6});
        bus_write(4'd6, 32'd0);
        @(negedge clk);
        cmd_ready = 1'b1;
        draw_done = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        draw_done = 1'b0;
        #1;
        chk("same_cycle_idle", bus.slave_waitrequest, 0);
        chk("same_cycle_valid", cmd_valid, 0);
        bus_read(4'd0, 32'h0002_0000 | IRQB, "status_two_plots", w);

        // Write during WAIT_DONE is held off
        plot_handshake({9'd319, 8'd239, 7'd6});
        fork
            begin
                bus_write(4'd2, 32'd13);
                bg_done = 1'b1;
            end
        join_none
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            #3;
            if (cmd_y !== 8'd239) bad++;
        end
        @(negedge clk);
        draw_done = 1'b1;
        #3;
        if (cmd_y !== 8'd239) bad++;
        chk("cmd_y_held", bad, 0);
        @(negedge clk);
        draw_done = 1'b0;
        n = 0;
        while (!bg_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("held_write_done", bg_done, 1);
        #3;
        chk("cmd_y_applied", cmd_y, 13);
        bus_read(4'd2, 32'd13, "y_after_held", w);
        bus_read(4'd0, 32'h0003_0000 | IRQB, "status_three_plots", w);
`ifdef RENDER_REGS_IRQ_EN
        chk("irq_pending", irq, 1);
`endif

        // Reset in the middle of WAIT_DONE
        plot_handshake({9'd319, 8'd13, 7'd6});
        @(negedge clk);
        #1;
        chk("wait_done_busy", bus.slave_waitrequest, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_cmd_valid", cmd_valid, 0);
        chk("midrst_busy", bus.slave_waitrequest, 0);
        chk("midrst_cmd_x", cmd_x, 0);
`ifdef RENDER_REGS_IRQ_EN
        chk("midrst_irq", irq, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Interrupt set and clear after reset
        cmd_q.push_back({9'd0, 8'd0, 7'd0});
        bus_write(4'd6, 32'd0);
        pulse_done();
        @(negedge clk);
        cmd_ready = 1'b1;
        draw_done = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        draw_done = 1'b0;
        #1;
`ifdef RENDER_REGS_IRQ_EN
        chk("irq_set", irq, 1);
`endif
        bus_read(4'd0, 32'h0001_0000 | IRQB, "status_irq_set", w);
        bus_write(4'd7, 32'd0);
`ifdef RENDER_REGS_IRQ_EN
        chk("irq_cleared", irq, 0);
`endif
        bus_read(4'd0, 32'h0001_0000, "status_irq_clear", w);

        repeat (3) @(negedge clk);
        chk("read_queue_empty", rd_q.size(), 0);
        chk("cmd_queue_empty", cmd_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
